// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types and encodings for the forwarding / hazard controller.
// Holds the per-stage shadow record and the operand-mux select encodings.
package fwd_hazard_ctrl_pkg;

    localparam int REG_ADDR_W_DFLT = 5;
    // Widest register address the shadow record can carry; narrower ids are zero-extended.
    localparam int DEST_W          = 8;

    localparam logic [1:0] FWD_RF   = 2'd0;
    localparam logic [1:0] FWD_WB   = 2'd1;
    localparam logic [1:0] FWD_MEM  = 2'd2;
    localparam logic [1:0] FWD_RSVD = 2'd3;

    typedef struct packed {
        logic              valid;
        logic [DEST_W-1:0] dest;
        logic              reg_write;
        logic              mem_read;
    } stage_info_t;

    localparam stage_info_t STAGE_BUBBLE = '0;

    // MEM wins over WB; register 0 is hard-wired and never forwarded.
    function automatic logic [1:0] fwd_select(
        input stage_info_t       mem,
        input stage_info_t       wb,
        input logic              uses,
        input logic [DEST_W-1:0] src
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (mem.valid && mem.reg_write && (mem.dest != '0) && uses && (mem.dest == src)) begin
            sel = FWD_MEM;
        end else if (wb.valid && wb.reg_write && (wb.dest != '0) && uses && (wb.dest == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_busy_cnt.sv
// Multi-cycle mul/div occupancy counter: loads when a mul/div enters EX,
// then counts down; busy while nonzero.
module muldiv_busy_cnt #(
    parameter int MULDIV_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic busy
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(MULDIV_CYCLES - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and hazard controller for the 5-stage pipeline.
// Keeps a shadow EX/MEM/WB copy and drives mux selects, stalls and flushes combinationally.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W    = REG_ADDR_W_DFLT,
    parameter int MULDIV_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_muldiv,
    input  logic                  ex_branch_taken,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  idex_hold,
    output logic                  exmem_bubble,
    output logic                  muldiv_busy
);

    stage_info_t           ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [REG_ADDR_W-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
    logic                  ex_uses_rs_q, ex_uses_rs_d, ex_uses_rt_q, ex_uses_rt_d;

    logic busy, flush, load_use, advance_id, muldiv_load;

    muldiv_busy_cnt #(
        .MULDIV_CYCLES (MULDIV_CYCLES),
        .CNT_W         (CNT_W)
    ) u_busy_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (muldiv_load),
        .busy  (busy)
    );

    always_comb begin
        load_use = ex_q.valid && ex_q.mem_read && (ex_q.dest != '0) && id_valid &&
                   ((id_uses_rs && (DEST_W'(id_rs) == ex_q.dest)) ||
                    (id_uses_rt && (DEST_W'(id_rt) == ex_q.dest)));
        // A taken branch kills the ID instruction, so it cannot cause a load-use stall.
        flush       = ex_branch_taken && !busy;
        advance_id  = !busy && !flush && !load_use && id_valid;
        muldiv_load = advance_id && id_muldiv;
    end

    always_comb begin
        fwd_a_sel = fwd_select(mem_q, wb_q, ex_uses_rs_q, DEST_W'(ex_rs_q));
        fwd_b_sel = fwd_select(mem_q, wb_q, ex_uses_rt_q, DEST_W'(ex_rt_q));
    end

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        idex_hold    = 1'b0;
        exmem_bubble = 1'b0;
        muldiv_busy  = busy;
        if (busy) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_hold    = 1'b1;
            exmem_bubble = 1'b1;
        end else if (flush) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Shadow advance mirrors what the pipeline registers do under the same controls.
    always_comb begin
        wb_d         = mem_q;
        mem_d        = ex_q;
        ex_d         = ex_q;
        ex_rs_d      = ex_rs_q;
        ex_rt_d      = ex_rt_q;
        ex_uses_rs_d = ex_uses_rs_q;
        ex_uses_rt_d = ex_uses_rt_q;
        if (busy) begin
            mem_d = STAGE_BUBBLE;
        end else if (advance_id) begin
            ex_d.valid     = 1'b1;
            ex_d.dest      = DEST_W'(id_dest);
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
            ex_rs_d        = id_rs;
            ex_rt_d        = id_rt;
            ex_uses_rs_d   = id_uses_rs;
            ex_uses_rt_d   = id_uses_rt;
        end else begin
            ex_d         = STAGE_BUBBLE;
            ex_rs_d      = '0;
            ex_rt_d      = '0;
            ex_uses_rs_d = 1'b0;
            ex_uses_rt_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q         <= STAGE_BUBBLE;
            mem_q        <= STAGE_BUBBLE;
            wb_q         <= STAGE_BUBBLE;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_uses_rs_q <= 1'b0;
            ex_uses_rt_q <= 1'b0;
        end else begin
            ex_q         <= ex_d;
            mem_q        <= mem_d;
            wb_q         <= wb_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_uses_rs_q <= ex_uses_rs_d;
            ex_uses_rt_q <= ex_uses_rt_d;
        end
    end

endmodule
